// File: rtl/usb_device_responder.sv
// usb_device_responder: device-side USB protocol responder answering host OUT/IN tokens
module usb_device_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'd5,
    parameter int         TIMEOUT_CYC = 20,
    parameter int         MAX_RETRY   = 8
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [6:0]  rx_addr,
    input  logic [3:0]  rx_endp,
    input  logic [63:0] rx_data,
    input  logic        rx_corrupted,
    input  logic        tx_ready,
    output logic        pktready,
    output logic        pkttype,
    output logic [3:0]  pid_out,
    output logic [63:0] data_out,
    output logic        app_out_valid,
    output logic [3:0]  app_out_endp,
    output logic [63:0] app_out_data,
    input  logic        app_in_avail,
    input  logic [63:0] app_in_data,
    output logic        app_in_done,
    output logic        xact_err,
    output logic        idle
);
    localparam logic [3:0] PID_OUT  = 4'b0001;
    localparam logic [3:0] PID_IN   = 4'b1001;
    localparam logic [3:0] PID_DATA = 4'b0011;
    localparam logic [3:0] PID_ACK  = 4'b0010;
    localparam logic [3:0] PID_NAK  = 4'b1010;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT, TX} state_t;

    state_t        state, state_n, ret_state, ret_n;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] retry, retry_n;
    logic [63:0]   payload, payload_n;
    logic [3:0]    endp, endp_n;
    logic          pktready_n, pkttype_n, app_out_valid_n, app_in_done_n, xact_err_n, idle_n;
    logic [3:0]    pid_n, app_out_endp_n;
    logic [63:0]   data_n, app_out_data_n;
    logic          tok, pkt_ok, timeout;

    assign tok     = rx_valid && !rx_corrupted && rx_addr == DEV_ADDR;
    assign pkt_ok  = rx_valid && !rx_corrupted;
    assign timeout = timer == TW'(TIMEOUT_CYC - 1);

    // next-state and next-output logic; every output is registered below
    always_comb begin
        state_n         = state;
        ret_n           = ret_state;
        timer_n         = timer;
        retry_n         = retry;
        payload_n       = payload;
        endp_n          = endp;
        pktready_n      = pktready;
        pkttype_n       = pkttype;
        pid_n           = pid_out;
        data_n          = data_out;
        app_out_valid_n = 1'b0;
        app_out_endp_n  = app_out_endp;
        app_out_data_n  = app_out_data;
        app_in_done_n   = 1'b0;
        xact_err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (tok && rx_pid == PID_OUT) begin
                    endp_n  = rx_endp;
                    timer_n = '0;
                    state_n = OUT_WAIT;
                end else if (tok && rx_pid == PID_IN) begin
                    endp_n     = rx_endp;
                    state_n    = TX;
                    pktready_n = 1'b1;
                    if (app_in_avail) begin
                        payload_n = app_in_data;
                        retry_n   = RW'(1);
                        pkttype_n = 1'b1;
                        pid_n     = PID_DATA;
                        data_n    = app_in_data;
                        ret_n     = IN_WAIT;
                    end else begin
                        pkttype_n = 1'b0;
                        pid_n     = PID_NAK;
                        data_n    = '0;
                        ret_n     = IDLE;
                    end
                end
            end
            OUT_WAIT: begin
                if (rx_valid && rx_pid == PID_DATA) begin
                    state_n    = TX;
                    pktready_n = 1'b1;
                    pkttype_n  = 1'b0;
                    data_n     = '0;
                    pid_n      = rx_corrupted ? PID_NAK : PID_ACK;
                    ret_n      = rx_corrupted ? OUT_WAIT : IDLE;
                    if (!rx_corrupted) begin
                        app_out_valid_n = 1'b1;
                        app_out_endp_n  = endp;
                        app_out_data_n  = rx_data;
                    end
                end else if (timeout) begin
                    xact_err_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            IN_WAIT: begin
                if (pkt_ok && rx_pid == PID_ACK) begin
                    app_in_done_n = 1'b1;
                    state_n       = IDLE;
                end else if ((pkt_ok && rx_pid == PID_NAK) || timeout) begin
                    if (retry == RW'(MAX_RETRY)) begin
                        xact_err_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        retry_n    = retry + RW'(1);
                        state_n    = TX;
                        pktready_n = 1'b1;
                        pkttype_n  = 1'b1;
                        pid_n      = PID_DATA;
                        data_n     = payload;
                        ret_n      = IN_WAIT;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            TX: begin
                if (tx_ready) begin
                    state_n    = ret_state;
                    timer_n    = '0;
                    pktready_n = 1'b0;
                    pkttype_n  = 1'b0;
                    pid_n      = '0;
                    data_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        idle_n = state_n == IDLE;
    end

    // state and output registers; reset drops any pending response
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            timer         <= '0;
            retry         <= '0;
            payload       <= '0;
            endp          <= '0;
            pktready      <= 1'b0;
            pkttype       <= 1'b0;
            pid_out       <= '0;
            data_out      <= '0;
            app_out_valid <= 1'b0;
            app_out_endp  <= '0;
            app_out_data  <= '0;
            app_in_done   <= 1'b0;
            xact_err      <= 1'b0;
            idle          <= 1'b1;
        end else begin
            state         <= state_n;
            ret_state     <= ret_n;
            timer         <= timer_n;
            retry         <= retry_n;
            payload       <= payload_n;
            endp          <= endp_n;
            pktready      <= pktready_n;
            pkttype       <= pkttype_n;
            pid_out       <= pid_n;
            data_out      <= data_n;
            app_out_valid <= app_out_valid_n;
            app_out_endp  <= app_out_endp_n;
            app_out_data  <= app_out_data_n;
            app_in_done   <= app_in_done_n;
            xact_err      <= xact_err_n;
            idle          <= idle_n;
        end
    end
endmodule
